// File: rtl/rcb_io_pkg.sv
// Shared types and constants for the NC/NO contact conditioning logic.
package rcb_io_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RELEASED = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_FAULT    = 2'd3
    } pair_state_e;

    localparam logic [1:0] CODE_REL = 2'b10;
    localparam logic [1:0] CODE_PRS = 2'b01;

    localparam int DEF_TICK_DIV    = 100;
    localparam int DEF_DEB_TICKS   = 5000;
    localparam int DEF_FAULT_TICKS = 20000;

    // Both contacts open or both closed means a broken or shorted switch.
    function automatic logic is_bad_code(input logic [1:0] code);
        return (code != CODE_REL) && (code != CODE_PRS);
    endfunction

endpackage

// File: rtl/nc_no_pair_ch.sv
// One NC/NO contact pair: synchroniser, stability counter, debounce/fault FSM
// and registered status outputs.
module nc_no_pair_ch
    import rcb_io_pkg::*;
#(
    parameter int DEB_TICKS   = DEF_DEB_TICKS,
    parameter int FAULT_TICKS = DEF_FAULT_TICKS
) (
    input  logic clk_100m,
    input  logic rst_n,
    input  logic tick,
    input  logic raw_nc,
    input  logic raw_no,
    input  logic fault_clr,
    output logic pressed,
    output logic valid,
    output logic fault,
    output logic chg_req
);

    localparam int CW = $clog2(FAULT_TICKS + 1);

    logic [1:0]    sync_p0;
    logic [1:0]    sync_p1;
    logic [1:0]    code_q;
    logic [CW-1:0] stab_cnt;
    pair_state_e   state;
    pair_state_e   state_nxt;
    logic          stable_rel;
    logic          stable_prs;
    logic          stable_bad;
    logic          pressed_nxt;
    logic          fault_nxt;

    // Stage boundary: raw contacts -> two-flop synchroniser -> previous code
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0  <= 2'b00;
            sync_p1  <= 2'b00;
            code_q   <= 2'b00;
            stab_cnt <= '0;
        end else begin
            sync_p0 <= {raw_nc, raw_no};
            sync_p1 <= sync_p0;
            code_q  <= sync_p1;
            if (sync_p1 != code_q)
                stab_cnt <= '0;
            else if (tick && (stab_cnt != CW'(FAULT_TICKS)))
                stab_cnt <= stab_cnt + CW'(1);
        end
    end

    // stab_cnt always describes how long code_q has been held.
    assign stable_rel = (code_q == CODE_REL) && (stab_cnt >= CW'(DEB_TICKS));
    assign stable_prs = (code_q == CODE_PRS) && (stab_cnt >= CW'(DEB_TICKS));
    assign stable_bad = is_bad_code(code_q) && (stab_cnt >= CW'(FAULT_TICKS));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: begin
                if (stable_rel)      state_nxt = ST_RELEASED;
                else if (stable_prs) state_nxt = ST_PRESSED;
                else if (stable_bad) state_nxt = ST_FAULT;
            end
            ST_RELEASED: begin
                if (stable_prs)      state_nxt = ST_PRESSED;
                else if (stable_bad) state_nxt = ST_FAULT;
            end
            ST_PRESSED: begin
                if (stable_rel)      state_nxt = ST_RELEASED;
                else if (stable_bad) state_nxt = ST_FAULT;
            end
            ST_FAULT: begin
                // A fault that is still being asserted beats a clear request.
                if (!stable_bad && fault_clr) state_nxt = ST_INIT;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_nxt;
    end

    // Stage boundary: FSM state -> registered status outputs
    assign pressed_nxt = (state == ST_PRESSED);
    assign fault_nxt   = (state == ST_FAULT);

    // Outputs showing neither valid nor fault mean INIT; leaving it is silent.
    assign chg_req = (valid || fault) &&
                     ((pressed_nxt != pressed) || (fault_nxt != fault));

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            pressed <= 1'b0;
            valid   <= 1'b0;
            fault   <= 1'b0;
        end else begin
            pressed <= pressed_nxt;
            valid   <= (state == ST_RELEASED) || (state == ST_PRESSED);
            fault   <= fault_nxt;
        end
    end

endmodule

// File: rtl/nc_no_pair_filter.sv
// Conditions N_PAIRS dual-contact switches: shared debounce tick, one channel
// per pair and a single registered change strobe.
module nc_no_pair_filter
    import rcb_io_pkg::*;
#(
    parameter int N_PAIRS     = 8,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int DEB_TICKS   = DEF_DEB_TICKS,
    parameter int FAULT_TICKS = DEF_FAULT_TICKS
) (
    input  logic               clk_100m,
    input  logic               rst_n,
    input  logic [N_PAIRS-1:0] raw_nc,
    input  logic [N_PAIRS-1:0] raw_no,
    input  logic [N_PAIRS-1:0] fault_clr,
    output logic [N_PAIRS-1:0] pressed,
    output logic [N_PAIRS-1:0] valid,
    output logic [N_PAIRS-1:0] fault,
    output logic               change
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [N_PAIRS-1:0] chg_req;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    for (genvar g = 0; g < N_PAIRS; g++) begin : g_pair
        nc_no_pair_ch #(
            .DEB_TICKS   (DEB_TICKS),
            .FAULT_TICKS (FAULT_TICKS)
        ) u_ch (
            .clk_100m  (clk_100m),
            .rst_n     (rst_n),
            .tick      (tick),
            .raw_nc    (raw_nc[g]),
            .raw_no    (raw_no[g]),
            .fault_clr (fault_clr[g]),
            .pressed   (pressed[g]),
            .valid     (valid[g]),
            .fault     (fault[g]),
            .chg_req   (chg_req[g])
        );
    end

    // Stage boundary: per-pair change requests -> one registered strobe
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) change <= 1'b0;
        else        change <= |chg_req;
    end

endmodule

// File: tb/tb_nc_no_pair_filter.sv
// Directed bench for nc_no_pair_filter with TICK_DIV=4, DEB_TICKS=5, FAULT_TICKS=20.
module tb_nc_no_pair_filter;

    localparam int NP = 8;

    logic          clk_100m = 1'b0;
    logic          rst_n;
    logic [NP-1:0] raw_nc;
    logic [NP-1:0] raw_no;
    logic [NP-1:0] fault_clr;
    logic [NP-1:0] pressed;
    logic [NP-1:0] valid;
    logic [NP-1:0] fault;
    logic          change;

    int checks = 0;
    int errors = 0;
    int chg_cnt = 0;
    int p0_drop = 0;
    int f0_seen = 0;
    int lat;

    nc_no_pair_filter #(
        .N_PAIRS     (NP),
        .TICK_DIV    (4),
        .DEB_TICKS   (5),
        .FAULT_TICKS (20)
    ) dut (
        .clk_100m  (clk_100m),
        .rst_n     (rst_n),
        .raw_nc    (raw_nc),
        .raw_no    (raw_no),
        .fault_clr (fault_clr),
        .pressed   (pressed),
        .valid     (valid),
        .fault     (fault),
        .change    (change)
    );

    always #5 clk_100m = ~clk_100m;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    function automatic logic get_bit(input int kind, input int idx);
        case (kind)
            0:       return pressed[idx];
            1:       return valid[idx];
            default: return fault[idx];
        endcase
    endfunction

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_100m);
            if (change === 1'b1) chg_cnt++;
            if (pressed[0] !== 1'b1) p0_drop++;
            if (fault[0] !== 1'b0) f0_seen++;
        end
    endtask

    // Returns the number of negedges until the bit reaches val, or -1.
    task automatic wait_bit(input int kind, input int idx, input logic val,
                            input int bound, output int cycles);
        cycles = -1;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk_100m);
            if (change === 1'b1) chg_cnt++;
            if (get_bit(kind, idx) === val) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic set_pair(input int idx, input logic nc, input logic no);
        raw_nc[idx] = nc;
        raw_no[idx] = no;
    endtask

    initial begin
        rst_n     = 1'b0;
        raw_nc    = '1;
        raw_no    = '0;
        fault_clr = '0;

        // Reset state
        run(3);
        chk("rst_pressed", int'(pressed), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_change", int'(change), 0);

        // 1: stable REL after reset, silent first acceptance
        rst_n   = 1'b1;
        chg_cnt = 0;
        wait_bit(1, 0, 1'b1, 40, lat);
        chk_rng("init_valid_lat", lat, 1, 26);
        chk("init_pressed0", int'(pressed[0]), 0);
        run(4);
        chk("init_change_cnt", chg_cnt, 0);
        chk("init_all_valid", int'(valid), 8'hFF);

        // 2: press, one change pulse
        chg_cnt = 0;
        set_pair(0, 1'b0, 1'b1);
        wait_bit(0, 0, 1'b1, 40, lat);
        chk_rng("press_lat", lat, 22, 26);
        run(5);
        chk("press_change_cnt", chg_cnt, 1);
        set_pair(0, 1'b1, 1'b0);
        wait_bit(0, 0, 1'b0, 40, lat);
        chk_rng("release_lat", lat, 22, 26);
        run(5);
        // press with a 3-cycle bounce at cycle 10: count restarts
        set_pair(0, 1'b0, 1'b1);
        run(10);
        set_pair(0, 1'b1, 1'b0);
        run(3);
        set_pair(0, 1'b0, 1'b1);
        wait_bit(0, 0, 1'b1, 40, lat);
        chk_rng("bounce_press_lat", lat, 22, 26);
        run(5);

        // 3: short BAD (11 for 40 cycles) is ignored
        p0_drop = 0;
        f0_seen = 0;
        set_pair(0, 1'b1, 1'b1);
        run(40);
        chk("shortbad_pressed_drop", p0_drop, 0);
        chk("shortbad_fault_seen", f0_seen, 0);
        chk("shortbad_valid0", int'(valid[0]), 1);
        set_pair(0, 1'b1, 1'b0);
        wait_bit(0, 0, 1'b0, 40, lat);
        chk_rng("shortbad_release_lat", lat, 22, 26);
        run(5);

        // 4: sustained BAD (00) declares a sticky fault
        chg_cnt = 0;
        set_pair(0, 1'b0, 1'b0);
        wait_bit(2, 0, 1'b1, 120, lat);
        chk_rng("fault_lat", lat, 80, 86);
        chk("fault_valid0", int'(valid[0]), 0);
        chk("fault_pressed0", int'(pressed[0]), 0);
        if (lat > 0 && lat < 100) run(100 - lat);
        chk("fault_change_cnt", chg_cnt, 1);
        // clear while BAD still present: fault holds
        chg_cnt = 0;
        fault_clr = 8'h01;
        run(1);
        fault_clr = '0;
        run(3);
        chk("clr_under_bad_fault0", int'(fault[0]), 1);
        chk("clr_under_bad_change", chg_cnt, 0);
        // restore REL: still faulted until cleared
        set_pair(0, 1'b1, 1'b0);
        run(30);
        chk("restored_fault_sticky", int'(fault[0]), 1);
        chg_cnt = 0;
        fault_clr = 8'h01;
        run(1);
        fault_clr = '0;
        run(4);
        chk("clr_fault0", int'(fault[0]), 0);
        chk("clr_revalid0", int'(valid[0]), 1);
        chk("clr_pressed0", int'(pressed[0]), 0);
        chk("clr_change_cnt", chg_cnt, 1);
        run(5);

        // 5: pairs 2 and 5 pressed together
        chg_cnt = 0;
        set_pair(2, 1'b0, 1'b1);
        set_pair(5, 1'b0, 1'b1);
        wait_bit(0, 2, 1'b1, 40, lat);
        chk_rng("multi_lat", lat, 22, 26);
        chk("multi_pressed5", int'(pressed[5]), 1);
        run(5);
        chk("multi_pressed", int'(pressed), 8'h24);
        chk("multi_change_cnt", chg_cnt, 1);

        // 6: asynchronous reset mid-debounce
        set_pair(0, 1'b0, 1'b1);
        run(10);
        @(posedge clk_100m);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_pressed", int'(pressed), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_fault", int'(fault), 0);
        chk("arst_change", int'(change), 0);
        run(2);
        rst_n   = 1'b1;
        chg_cnt = 0;
        wait_bit(1, 0, 1'b1, 40, lat);
        chk_rng("arst_revalid_lat", lat, 20, 26);
        chk("arst_pressed0", int'(pressed[0]), 1);
        run(4);
        chk("arst_change_cnt", chg_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
